hub75_scan_driver: RTL and testbench

- Downstream consumer of the triple-buffered frame store on the read clock.
- Scans a 64x64 HUB75 panel as two 32-row halves: top pixel on douta, bottom pixel on doutb, both at the same addrb.
- Generates 8-plane binary-code modulation (BCM) and the panel signals R1/G1/B1, R2/G2/B2, CLK, LAT, OE_n and row address A–E.
- Pulses frame_done at end of each frame so the buffer-rotation logic can advance buffer_sel.

---
 rtl/hub75_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: reads the frame store and drives a 64x64 panel as two 32-row halves,
// using 8-plane binary-code modulation. All panel-facing outputs are registered.
module hub75_scan_driver #(
    parameter int COLS       = 64,
    parameter int ROWS       = 32,
    parameter int BITS       = 8,
    parameter int BASE_TICKS = 16
) (
    input  logic        clkb,
    input  logic        reset,
    input  logic        enable,
    output logic [10:0] addrb,
    input  logic [23:0] douta,
    input  logic [23:0] doutb,
    output logic [2:0]  rgb_top,
    output logic [2:0]  rgb_bot,
    output logic        sclk,
    output logic        lat,
    output logic        oe_n,
    output logic [4:0]  row_addr,
    output logic        frame_done,
    output logic        busy
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(BITS);
    localparam int TW = $clog2(BASE_TICKS << (BITS - 1)) + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        SHIFT    = 3'd2,
        BLANK    = 3'd3,
        LATCH    = 3'd4,
        DISPLAY  = 3'd5
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] col, col_inc;
    logic          phase;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic [TW-1:0] tick, disp_len;
    logic          disp_end, last_plane, last_row;
    logic [10:0]   row_base;

    logic [10:0]   addrb_n;
    logic [2:0]    rgb_top_n, rgb_bot_n;
    logic          sclk_n, lat_n, oe_n_n, frame_done_n, busy_n;
    logic [4:0]    row_addr_n;

    // Picks bit p of each 8-bit channel of a packed {R,G,B} pixel.
    function automatic logic [2:0] plane_bits(input logic [23:0] px, input logic [PW-1:0] p);
        logic [23:0] s;
        s = px >> p;
        return {s[16], s[8], s[0]};
    endfunction

    assign col_inc    = col + CW'(1);
    assign disp_len   = TW'(BASE_TICKS) << plane;
    assign disp_end   = (tick == disp_len - TW'(1));
    assign last_plane = (plane == PW'(BITS - 1));
    assign last_row   = (row == RW'(ROWS - 1));
    assign row_base   = 11'(row) << CW;

    // State register.
    always_ff @(posedge clkb or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; enable only matters in IDLE and at the end of a frame.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = enable ? PREFETCH : IDLE;
            PREFETCH: next_state = (tick == TW'(1)) ? SHIFT : PREFETCH;
            SHIFT:    next_state = (phase && col == CW'(COLS - 1)) ? BLANK : SHIFT;
            BLANK:    next_state = LATCH;
            LATCH:    next_state = DISPLAY;
            DISPLAY: begin
                if (!disp_end)                   next_state = DISPLAY;
                else if (last_plane && last_row) next_state = enable ? PREFETCH : IDLE;
                else                             next_state = PREFETCH;
            end
            default:  next_state = IDLE;
        endcase
    end

    // Scan position: tick restarts on every state change, column wraps after the last shift.
    always_ff @(posedge clkb or posedge reset) begin
        if (reset) begin
            tick  <= '0;
            col   <= '0;
            phase <= 1'b0;
            row   <= '0;
            plane <= '0;
        end else begin
            if (next_state != state) tick <= '0;
            else                     tick <= tick + TW'(1);
            if (state == SHIFT) begin
                phase <= ~phase;
                if (phase) col <= col_inc;
            end else begin
                phase <= 1'b0;
            end
            if (state == DISPLAY && disp_end) begin
                if (!last_plane) begin
                    plane <= plane + PW'(1);
                end else begin
                    plane <= '0;
                    row   <= last_row ? '0 : row + RW'(1);
                end
            end
        end
    end

    // Output decode; addrb is issued two cycles ahead of the rgb load for the same column.
    always_comb begin
        addrb_n      = addrb;
        rgb_top_n    = rgb_top;
        rgb_bot_n    = rgb_bot;
        sclk_n       = 1'b0;
        lat_n        = 1'b0;
        oe_n_n       = 1'b1;
        row_addr_n   = row_addr;
        frame_done_n = 1'b0;
        busy_n       = (next_state != IDLE);
        case (state)
            PREFETCH: begin
                if (tick == '0) addrb_n = row_base;
                else            addrb_n = addrb;
            end
            SHIFT: begin
                if (!phase) begin
                    rgb_top_n = plane_bits(douta, plane);
                    rgb_bot_n = plane_bits(doutb, plane);
                    addrb_n   = row_base | 11'(col_inc);
                end else begin
                    sclk_n = 1'b1;
                end
            end
            BLANK:    row_addr_n = 5'(row);
            LATCH:    lat_n = 1'b1;
            DISPLAY: begin
                oe_n_n = 1'b0;
                if (disp_end && last_plane && last_row) frame_done_n = 1'b1;
                else                                    frame_done_n = 1'b0;
            end
            default:  oe_n_n = 1'b1;
        endcase
    end

    // Output registers.
    always_ff @(posedge clkb or posedge reset) begin
        if (reset) begin
            addrb      <= 11'd0;
            rgb_top    <= 3'd0;
            rgb_bot    <= 3'd0;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= 5'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            addrb      <= addrb_n;
            rgb_top    <= rgb_top_n;
            rgb_bot    <= rgb_bot_n;
            sclk       <= sclk_n;
            lat        <= lat_n;
            oe_n       <= oe_n_n;
            row_addr   <= row_addr_n;
            frame_done <= frame_done_n;
            busy       <= busy_n;
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: directed stimulus queues expected shifts, BCM lengths, latch rows
// and frame periods; a falling-edge monitor drains the queues as the panel signals appear.
module tb_hub75_scan_driver;
    localparam int COLS  = 64;
    localparam int ROWS  = 4;
    localparam int BITS  = 8;
    localparam int BT    = 1;
    localparam int FRAME = ROWS * (BITS * (4 + 2 * COLS) + BT * ((1 << BITS) - 1));

    logic        clkb   = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] addrb;
    logic [23:0] douta, doutb;
    logic [2:0]  rgb_top, rgb_bot;
    logic        sclk, lat, oe_n, frame_done, busy;
    logic [4:0]  row_addr;
    int          mode = 0;

    hub75_scan_driver #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_TICKS(BT)) dut (
        .clkb(clkb), .reset(reset), .enable(enable), .addrb(addrb),
        .douta(douta), .doutb(doutb), .rgb_top(rgb_top), .rgb_bot(rgb_bot),
        .sclk(sclk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clkb = ~clkb;

    // Frame-store model with one cycle of read latency.
    always @(posedge clkb) begin
        if (mode == 0) begin
            douta <= {3{addrb[7:0]}};
            doutb <= {3{~addrb[7:0]}};
        end else begin
            douta <= 24'hA53CFF;
            doutb <= 24'h000001;
        end
    end

    typedef struct {
        logic [10:0] addr;
        logic [2:0]  top;
        logic [2:0]  bot;
    } col_t;

    col_t exp_col[$];
    int   exp_oe[$];
    int   exp_row[$];
    int   exp_fd[$];
    logic idle_q[$];
    logic ev_q[$];
    logic mon_on = 1'b0, done_req = 1'b0, done_ack = 1'b0;
    int   checks = 0, passes = 0;

    logic [10:0] a_d1 = 11'd0, a_d2 = 11'd0, a_d3 = 11'd0;
    logic        sclk_d = 1'b0, oe_d = 1'b1, fd_d = 1'b0, lat_d = 1'b0;
    logic [4:0]  ra_d = 5'd0;
    int          cyc = 0, last_fd = 0, oe_len = 0, fd_want = 0;
    logic        full;
    col_t        mon_e;

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, got, want, cyc);
    endtask

    task automatic push_frame(input int m);
        logic [7:0] a;
        logic [2:0] top_b [8];
        col_t       e;
        top_b = '{3'd5, 3'd1, 3'd7, 3'd3, 3'd3, 3'd7, 3'd1, 3'd5};
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < BITS; p++) begin
                for (int c = 0; c < COLS; c++) begin
                    a      = 8'(r * COLS + c);
                    e.addr = 11'(r * COLS + c);
                    if (m == 0) begin
                        e.top = {3{a[p]}};
                        e.bot = {3{~a[p]}};
                    end else begin
                        e.top = top_b[p];
                        e.bot = (p == 0) ? 3'b001 : 3'b000;
                    end
                    exp_col.push_back(e);
                end
                exp_oe.push_back(BT << p);
                exp_row.push_back(r);
            end
        end
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clkb);
            n++;
        end while (!frame_done && n < FRAME + 200);
        ev_q.push_back(frame_done);
    endtask

    // Monitor: samples on the falling edge and drains the scoreboard queues.
    always @(negedge clkb) begin
        a_d1   <= addrb;
        a_d2   <= a_d1;
        a_d3   <= a_d2;
        sclk_d <= sclk;
        oe_d   <= oe_n;
        ra_d   <= row_addr;
        fd_d   <= frame_done;
        lat_d  <= lat;
        cyc    <= cyc + 1;
        if (idle_q.size() > 0) begin
            full = idle_q.pop_front();
            check("idle_ctrl", {busy, oe_n, sclk, lat, frame_done}, 5'b01000);
            if (full) check("reset_data", {addrb, rgb_top, rgb_bot, row_addr}, 0);
        end
        if (ev_q.size() > 0) check("frame_done_wait", ev_q.pop_front(), 1);
        if (mon_on) begin
            if (sclk && !sclk_d) begin
                if (exp_col.size() == 0) begin
                    check("spare_sclk", exp_col.size(), 1);
                end else begin
                    mon_e = exp_col.pop_front();
                    check("shift_addr", a_d3, mon_e.addr);
                    check("shift_rgb", {rgb_top, rgb_bot}, {mon_e.top, mon_e.bot});
                end
            end
            if (!oe_n) begin
                oe_len <= oe_len + 1;
            end else if (!oe_d) begin
                if (exp_oe.size() > 0) check("oe_low_len", oe_len, exp_oe.pop_front());
                else                   check("spare_oe", exp_oe.size(), 1);
                oe_len <= 0;
            end
            if (lat) begin
                check("lat_ctrl", {sclk, oe_n}, 2'b01);
                check("lat_width", lat_d, 0);
                if (exp_row.size() > 0) check("lat_row", row_addr, exp_row.pop_front());
                else                    check("spare_lat", exp_row.size(), 1);
            end
            if (row_addr != ra_d) check("row_change_oe", oe_n, 1);
            if (frame_done) begin
                check("fd_width", fd_d, 0);
                if (exp_fd.size() > 0) begin
                    fd_want = exp_fd.pop_front();
                    if (fd_want >= 0) check("fd_period", cyc - last_fd, fd_want);
                end else begin
                    check("spare_fd", exp_fd.size(), 1);
                end
                last_fd <= cyc;
            end
        end
        if (done_req && !done_ack) begin
            check("left_shift", exp_col.size(), 0);
            check("left_oe", exp_oe.size(), 0);
            check("left_lat", exp_row.size(), 0);
            check("left_fd", exp_fd.size(), 0);
            done_ack <= 1'b1;
        end
    end

    initial begin
        // Reset mid-SHIFT, then hold in reset state with enable low.
        repeat (3) @(posedge clkb);
        #1 reset = 1'b0;
        enable = 1'b1;
        repeat (40) @(posedge clkb);
        #2 reset = 1'b1;
        idle_q.push_back(1'b1);
        @(posedge clkb);
        #1 enable = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) idle_q.push_back(1'b1);
        repeat (101) @(posedge clkb);

        // Address-pattern frame; enable dropped after 1000 cycles.
        mode = 0;
        push_frame(0);
        exp_fd.push_back(-1);
        mon_on = 1'b1;
        #1 enable = 1'b1;
        repeat (1000) @(posedge clkb);
        #1 enable = 1'b0;
        wait_fd();
        repeat (2) @(posedge clkb);
        #1 for (int i = 0; i < 20; i++) idle_q.push_back(1'b0);
        repeat (22) @(posedge clkb);

        // Constant-pixel frames back to back, stopping at the second frame boundary.
        mode = 1;
        push_frame(1);
        push_frame(1);
        exp_fd.push_back(-1);
        exp_fd.push_back(FRAME);
        #1 enable = 1'b1;
        wait_fd();
        repeat (1000) @(posedge clkb);
        #1 enable = 1'b0;
        wait_fd();
        repeat (2) @(posedge clkb);
        #1 for (int i = 0; i < 20; i++) idle_q.push_back(1'b0);
        repeat (22) @(posedge clkb);

        done_req = 1'b1;
        for (int i = 0; i < 10 && !done_ack; i++) @(posedge clkb);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
